// File: rtl/appr_err_monitor.sv
`default_nettype none
// ============================================================================
// appr_err_monitor : exact-vs-approximate 16x16 multiplier error statistics
// Rev 1.0
// ============================================================================
module appr_err_monitor #(
   parameter int W    = 16,
   parameter int FRAC = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [W-1:0]       in_a,
   input  logic signed [W-1:0]       in_b,
   input  logic signed [2*W-1:0]     in_appr,
   output logic                      out_valid,
   output logic signed [2*W-FRAC:0]  out_err,
   output logic [31:0]               sample_cnt,
   output logic signed [55:0]        err_sum,
   output logic [63:0]               err_sq_sum,
   output logic [2*W-FRAC:0]         err_max_abs,
   output logic                      sq_sat
);

   localparam int PW = 2 * W;
   localparam int QW = PW - FRAC;
   localparam int EW = QW + 1;
   localparam int SW = 2 * EW;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ERR  = 2'd2,
      ACC  = 2'd3
   } state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        bit_cnt;
   logic [PW-1:0]        mcand;
   logic [PW-1:0]        prod;
   logic [W-1:0]         mplier;
   logic                 neg;
   logic signed [QW-1:0] appr_q;
   logic signed [EW-1:0] err_r;

   logic                 accept;
   logic [W-1:0]         mag_a, mag_b;
   logic signed [PW-1:0] exact;
   logic signed [EW-1:0] err_w;
   logic [EW-1:0]        abs_err;
   logic [SW-1:0]        sq;
   logic [64:0]          sq_sum_w;

   assign in_ready = (state == IDLE) && !clr && (sample_cnt != 32'hFFFF_FFFF);
   assign accept   = in_valid && in_ready;

   // Magnitudes are unsigned so that -32768 maps cleanly to 32768.
   assign mag_a = in_a[W-1] ? W'(-in_a) : W'(in_a);
   assign mag_b = in_b[W-1] ? W'(-in_b) : W'(in_b);

   assign exact    = neg ? -$signed(prod) : $signed(prod);
   assign err_w    = EW'(appr_q) - EW'(exact >>> FRAC);
   assign abs_err  = err_r[EW-1] ? EW'(-err_r) : EW'(err_r);
   assign sq       = SW'(abs_err) * SW'(abs_err);
   assign sq_sum_w = {1'b0, err_sq_sum} + 65'(sq);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = MUL;
         MUL:     if (bit_cnt == CW'(W - 1)) state_nxt = ERR;
         ERR:     state_nxt = ACC;
         ACC:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (clr) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt     <= '0;
         mcand       <= '0;
         prod        <= '0;
         mplier      <= '0;
         neg         <= 1'b0;
         appr_q      <= '0;
         err_r       <= '0;
         out_valid   <= 1'b0;
         out_err     <= '0;
         sample_cnt  <= '0;
         err_sum     <= '0;
         err_sq_sum  <= '0;
         err_max_abs <= '0;
         sq_sat      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (clr) begin
            out_err     <= '0;
            sample_cnt  <= '0;
            err_sum     <= '0;
            err_sq_sum  <= '0;
            err_max_abs <= '0;
            sq_sat      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (accept) begin
                     appr_q  <= QW'(in_appr >>> FRAC);
                     mcand   <= PW'(mag_a);
                     mplier  <= mag_b;
                     prod    <= '0;
                     neg     <= in_a[W-1] ^ in_b[W-1];
                     bit_cnt <= '0;
                  end
               end
               MUL: begin
                  if (mplier[0]) prod <= prod + mcand;
                  mcand   <= mcand << 1;
                  mplier  <= mplier >> 1;
                  bit_cnt <= bit_cnt + CW'(1);
               end
               ERR: err_r <= err_w;
               ACC: begin
                  out_valid  <= 1'b1;
                  out_err    <= err_r;
                  sample_cnt <= sample_cnt + 32'd1;
                  err_sum    <= err_sum + 56'(err_r);
                  // Once saturated the sum stays pinned: any further add carries out.
                  if (sq_sum_w[64]) begin
                     err_sq_sum <= '1;
                     sq_sat     <= 1'b1;
                  end else begin
                     err_sq_sum <= sq_sum_w[63:0];
                  end
                  if (abs_err > err_max_abs) err_max_abs <= abs_err;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_appr_err_monitor.sv
`default_nettype none
// ============================================================================
// tb_appr_err_monitor : table, directed and random checks against a Q.12 model
// ============================================================================
module tb_appr_err_monitor;

   logic               clk = 1'b0;
   logic               rst, clr, in_valid, in_ready, out_valid, sq_sat;
   logic signed [15:0] in_a, in_b;
   logic signed [31:0] in_appr;
   logic signed [20:0] out_err;
   logic [31:0]        sample_cnt;
   logic signed [55:0] err_sum;
   logic [63:0]        err_sq_sum;
   logic [20:0]        err_max_abs;

   int n_cmp  = 0;
   int n_fail = 0;

   longint       m_cnt, m_sum, m_max;
   logic [127:0] m_sq;
   bit           m_sat;

   typedef struct {
      logic signed [15:0] a;
      logic signed [15:0] b;
      logic signed [31:0] appr;
      longint             err;
   } vec_t;

   vec_t vecs[7];

   appr_err_monitor #(.W(16), .FRAC(12)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_appr(in_appr), .out_valid(out_valid),
      .out_err(out_err), .sample_cnt(sample_cnt), .err_sum(err_sum),
      .err_sq_sum(err_sq_sum), .err_max_abs(err_max_abs), .sq_sat(sq_sat)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // Floor division by 2^12 written as plain integer arithmetic.
   function automatic longint floor_q(input longint x);
      longint q = x / 4096;
      if (x < 0 && q * 4096 != x) q = q - 1;
      return q;
   endfunction

   function automatic longint ref_err(input longint a, input longint b, input longint appr);
      return floor_q(appr) - floor_q(a * b);
   endfunction

   function automatic logic signed [31:0] mk_appr(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
      longint p = longint'(a) * longint'(b);
      if ($urandom_range(0, 3) == 0) return $urandom;
      return 32'(p + longint'($urandom_range(0, 262143)) - 131072);
   endfunction

   task automatic model_clear();
      m_cnt = 0; m_sum = 0; m_max = 0; m_sq = '0; m_sat = 1'b0;
   endtask

   task automatic model_commit(input longint e);
      m_cnt++;
      m_sum += e;
      m_sq  += 128'(e * e);
      if (m_sq > 128'(64'hFFFF_FFFF_FFFF_FFFF)) m_sat = 1'b1;
      if ((e < 0 ? -e : e) > m_max) m_max = (e < 0 ? -e : e);
   endtask

   task automatic check_stats();
      chk("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
      chk("err_sum", 64'(longint'(err_sum)), 64'(m_sum));
      chk("err_sq_sum", err_sq_sum, m_sat ? 64'hFFFF_FFFF_FFFF_FFFF : m_sq[63:0]);
      chk("err_max_abs", 64'(err_max_abs), 64'(m_max));
      chk("sq_sat", 64'(sq_sat), 64'(m_sat));
   endtask

   task automatic do_reset();
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   // Offers one sample, waits for its commit, checks latency and error.
   task automatic do_sample(input logic signed [15:0] a, input logic signed [15:0] b,
                            input logic signed [31:0] ap);
      int     t;
      int     lat;
      longint e;
      t = 0;
      while (!in_ready && t < 60) begin @(negedge clk); t++; end
      chk("ready_wait", 64'(in_ready), 64'd1);
      in_a = a; in_b = b; in_appr = ap; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_a = $urandom; in_b = $urandom; in_appr = $urandom;
      chk("busy_ready", 64'(in_ready), 64'd0);
      lat = 1;
      while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
      chk("latency", 64'(lat), 64'd19);
      chk("ready_at_commit", 64'(in_ready), 64'd1);
      e = ref_err(longint'(a), longint'(b), longint'(ap));
      model_commit(e);
      chk("out_err", 64'(longint'(out_err)), 64'(e));
   endtask

   initial begin
      logic signed [15:0] ra, rb;
      int                 pulses;
      int                 n_acc, n_out, cyc;
      vec_t               exp_q[$];
      int                 acc_cyc[$];
      vec_t               v;

      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_appr = '0;
      model_clear();

      vecs[0] = '{16'sd1000,   16'sd12288,  32'sd12288000,           0};
      vecs[1] = '{16'sd1000,   16'sd12288,  32'sd12292096,           1};
      vecs[2] = '{16'sd1000,   16'sd12288,  32'sd12279808,          -2};
      vecs[3] = '{16'sd1000,   16'sd12288,  32'sd12300288,           3};
      vecs[4] = '{-16'sd1000,  16'sd12288,  -32'sd12296192,         -2};
      vecs[5] = '{16'sd1,      16'sd1,      -32'sd1,                -1};
      vecs[6] = '{16'sh8000,   16'sh8000,   32'sh4000_0000,          0};

      do_reset();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_err", 64'(longint'(out_err)), 64'd0);
      check_stats();

      // Accumulation from a fresh reset with fixed expectations.
      do_sample(16'sd1000, 16'sd12288, 32'sd12292096);
      chk("acc_err1", 64'(longint'(out_err)), 64'd1);
      do_sample(16'sd1000, 16'sd12288, 32'sd12279808);
      chk("acc_err2", 64'(longint'(out_err)), -64'sd2);
      do_sample(16'sd1000, 16'sd12288, 32'sd12300288);
      chk("acc_err3", 64'(longint'(out_err)), 64'd3);
      chk("acc_sum", 64'(longint'(err_sum)), 64'd2);
      chk("acc_sq", err_sq_sum, 64'd14);
      chk("acc_max", 64'(err_max_abs), 64'd3);
      chk("acc_cnt", 64'(sample_cnt), 64'd3);
      @(negedge clk);
      chk("pulse_one_cycle", 64'(out_valid), 64'd0);

      for (int i = 0; i < 7; i++) begin
         do_sample(vecs[i].a, vecs[i].b, vecs[i].appr);
         chk("vec_err", 64'(longint'(out_err)), 64'(vecs[i].err));
      end
      check_stats();

      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 8 == 0) ra = 16'sh8000;
         if (i % 8 == 1) rb = 16'sh7FFF;
         do_sample(ra, rb, mk_appr(ra, rb));
         check_stats();
      end

      // Clear lands in the middle of MUL while a new sample is offered.
      in_a = 16'sd77; in_b = -16'sd5; in_appr = 32'sd123456; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      clr = 1'b1; in_valid = 1'b1; in_a = 16'sd3; in_b = 16'sd4; in_appr = 32'sd99999;
      @(negedge clk);
      model_clear();
      chk("clr_out_valid", 64'(out_valid), 64'd0);
      chk("clr_out_err", 64'(longint'(out_err)), 64'd0);
      chk("clr_ready_low", 64'(in_ready), 64'd0);
      check_stats();
      clr = 1'b0; in_valid = 1'b0;
      #1;
      chk("clr_ready_after", 64'(in_ready), 64'd1);
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      chk("clr_no_commit", 64'(pulses), 64'd0);
      check_stats();

      // Backpressure: in_valid held with fresh data every cycle.
      n_acc = 0; n_out = 0; cyc = 0;
      while (n_out < 3 && cyc < 100) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("bp_extra_valid", 64'(out_valid), 64'd0);
            end else begin
               v = exp_q.pop_front();
               model_commit(v.err);
               chk("bp_err", 64'(longint'(out_err)), 64'(v.err));
               n_out++;
            end
         end
         if (n_acc < 3) begin
            ra = $urandom; rb = $urandom;
            in_a = ra; in_b = rb; in_appr = mk_appr(ra, rb); in_valid = 1'b1;
            if (in_ready) begin
               exp_q.push_back('{ra, rb, in_appr,
                                 ref_err(longint'(ra), longint'(rb), longint'(in_appr))});
               acc_cyc.push_back(cyc);
               n_acc++;
            end
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      chk("bp_commits", 64'(n_out), 64'd3);
      chk("bp_accepts", 64'(acc_cyc.size()), 64'd3);
      if (acc_cyc.size() == 3) begin
         chk("bp_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd19);
         chk("bp_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd19);
      end
      check_stats();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
